// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream resets in order (core, video, audio). A lock loss
// after release has begun restarts the whole sequence and is counted.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 1048576,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int STAGE_GAP_CYCLES    = 256
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   output logic       pll_rst,
   output logic [2:0] rst_out,
   output logic       ready,
   output logic [7:0] lock_loss_count
);

   // Counter widths leave room for the terminal value itself, so no counter
   // ever needs to wrap.
   localparam int PR_W  = $clog2(PLL_RST_CYCLES + 1);
   localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int ST_W  = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int GAP_W = $clog2(2 * STAGE_GAP_CYCLES + 1);

   localparam logic [PR_W-1:0]  PR_LAST   = PR_W'(PLL_RST_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [ST_W-1:0]  ST_DONE   = ST_W'(LOCK_STABLE_CYCLES);
   localparam logic [GAP_W-1:0] GAP_STAGE = GAP_W'(STAGE_GAP_CYCLES);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(2 * STAGE_GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_PLL_RESET,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [PR_W-1:0]  pr_cnt_q, pr_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [ST_W-1:0]  st_cnt_q, st_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [7:0]       loss_q, loss_d;
   logic             sync1_q, locked_sync_q;
   logic             pll_rst_q, pll_rst_d;
   logic [2:0]       rst_out_q, rst_out_d;
   logic             ready_q, ready_d;

   // State, counters, lock synchroniser and registered outputs.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q       <= S_PLL_RESET;
         pr_cnt_q      <= '0;
         to_cnt_q      <= '0;
         st_cnt_q      <= '0;
         gap_cnt_q     <= '0;
         loss_q        <= '0;
         sync1_q       <= 1'b0;
         locked_sync_q <= 1'b0;
         pll_rst_q     <= 1'b1;
         rst_out_q     <= 3'b111;
         ready_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pr_cnt_q      <= pr_cnt_d;
         to_cnt_q      <= to_cnt_d;
         st_cnt_q      <= st_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         loss_q        <= loss_d;
         sync1_q       <= locked;
         locked_sync_q <= sync1_q;
         pll_rst_q     <= pll_rst_d;
         rst_out_q     <= rst_out_d;
         ready_q       <= ready_d;
      end
   end

   // Next-state and counter logic; only the synchronised lock steers it.
   always_comb begin
      state_d   = state_q;
      pr_cnt_d  = pr_cnt_q;
      to_cnt_d  = to_cnt_q;
      st_cnt_d  = st_cnt_q;
      gap_cnt_d = gap_cnt_q;
      loss_d    = loss_q;
      case (state_q)
         S_PLL_RESET: begin
            if (pr_cnt_q == PR_LAST) begin
               state_d  = S_WAIT_LOCK;
               to_cnt_d = '0;
            end else begin
               pr_cnt_d = pr_cnt_q + PR_W'(1);
            end
         end
         S_WAIT_LOCK: begin
            // Lock is checked first so it wins over a coincident timeout.
            if (locked_sync_q) begin
               state_d  = S_STABLE;
               st_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
               state_d  = S_PLL_RESET;
               pr_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         S_STABLE: begin
            // A glitch here is not a lock loss: just wait for lock again.
            if (!locked_sync_q) begin
               state_d  = S_WAIT_LOCK;
               to_cnt_d = '0;
               st_cnt_d = '0;
            end else if (st_cnt_q == ST_DONE) begin
               state_d   = S_RELEASE;
               gap_cnt_d = '0;
            end else begin
               st_cnt_d = st_cnt_q + ST_W'(1);
            end
         end
         S_RELEASE, S_RUN: begin
            if (!locked_sync_q) begin
               state_d  = S_PLL_RESET;
               pr_cnt_d = '0;
               if (loss_q != 8'hFF) begin
                  loss_d = loss_q + 8'd1;
               end
            end else if (state_q == S_RELEASE) begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
               if (gap_cnt_q == GAP_LAST) begin
                  state_d = S_RUN;
               end
            end
         end
         default: begin
            state_d  = S_PLL_RESET;
            pr_cnt_d = '0;
         end
      endcase
   end

   // Output decode from the next state, so outputs register with the state.
   // In RELEASE bit 0 is already low, bit 1 drops one gap later; bit 2 only
   // drops on entry to RUN, so the release order can never invert.
   always_comb begin
      pll_rst_d = (state_d == S_PLL_RESET);
      ready_d   = (state_d == S_RUN);
      case (state_d)
         S_RELEASE: rst_out_d = {1'b1, (gap_cnt_d < GAP_STAGE), 1'b0};
         S_RUN:     rst_out_d = 3'b000;
         default:   rst_out_d = 3'b111;
      endcase
   end

   assign pll_rst         = pll_rst_q;
   assign rst_out         = rst_out_q;
   assign ready           = ready_q;
   assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters.
module tb_pll_reset_sequencer;

   localparam int PRC = 4;
   localparam int LTC = 32;
   localparam int LSC = 8;
   localparam int SGC = 4;

   logic       refclk = 1'b0;
   logic       rst    = 1'b1;
   logic       locked = 1'b0;
   logic       pll_rst;
   logic [2:0] rst_out;
   logic       ready;
   logic [7:0] lock_loss_count;

   int checks = 0;
   int errors = 0;

   always #5 refclk = ~refclk;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES     (PRC),
      .LOCK_TIMEOUT_CYCLES(LTC),
      .LOCK_STABLE_CYCLES (LSC),
      .STAGE_GAP_CYCLES   (SGC)
   ) dut (
      .refclk         (refclk),
      .rst            (rst),
      .locked         (locked),
      .pll_rst        (pll_rst),
      .rst_out        (rst_out),
      .ready          (ready),
      .lock_loss_count(lock_loss_count)
   );

   typedef struct {
      logic       rst;
      logic       locked;
      int         n;
      logic       pll;
      logic [2:0] ro;
      logic       rdy;
      logic [7:0] llc;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic r, input logic l, input int n,
                               input logic p, input logic [2:0] ro,
                               input logic rdy, input logic [7:0] llc);
      vec_t v;
      v.rst = r; v.locked = l; v.n = n; v.pll = p; v.ro = ro; v.rdy = rdy; v.llc = llc;
      return v;
   endfunction

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   initial begin
      int exp_llc;
      int k;
      // Segments: inputs held for n edges, outputs checked after each edge.
      // Outputs packed as {pll_rst, rst_out, ready, lock_loss_count}.
      tbl[0]  = mk(1, 0, 3,  1, 3'b111, 0, 0);  // in reset
      tbl[1]  = mk(0, 0, 3,  1, 3'b111, 0, 0);  // rest of 4-cycle PLL reset
      tbl[2]  = mk(0, 0, 32, 0, 3'b111, 0, 0);  // full lock timeout window
      tbl[3]  = mk(0, 0, 4,  1, 3'b111, 0, 0);  // retry PLL reset
      tbl[4]  = mk(0, 0, 2,  0, 3'b111, 0, 0);  // waiting for lock
      tbl[5]  = mk(0, 1, 11, 0, 3'b111, 0, 0);  // E..E+10: sync + stable count
      tbl[6]  = mk(0, 1, 4,  0, 3'b110, 0, 0);  // E+11: core released
      tbl[7]  = mk(0, 1, 4,  0, 3'b100, 0, 0);  // E+15: video released
      tbl[8]  = mk(0, 1, 5,  0, 3'b000, 1, 0);  // E+19: audio + ready
      tbl[9]  = mk(0, 0, 2,  0, 3'b000, 1, 0);  // lock drop in sync pipe
      tbl[10] = mk(0, 0, 4,  1, 3'b111, 0, 1);  // lock loss -> PLL reset
      tbl[11] = mk(0, 0, 1,  0, 3'b111, 0, 1);  // waiting for lock
      tbl[12] = mk(0, 1, 5,  0, 3'b111, 0, 1);  // relock, partway into STABLE
      tbl[13] = mk(0, 0, 1,  0, 3'b111, 0, 1);  // one-cycle glitch
      tbl[14] = mk(0, 1, 11, 0, 3'b111, 0, 1);  // full restart of stable count
      tbl[15] = mk(0, 1, 4,  0, 3'b110, 0, 1);
      tbl[16] = mk(0, 1, 4,  0, 3'b100, 0, 1);
      tbl[17] = mk(0, 1, 1,  0, 3'b000, 1, 1);

      for (int s = 0; s < 18; s++) begin
         rst    = tbl[s].rst;
         locked = tbl[s].locked;
         for (int j = 0; j < tbl[s].n; j++) begin
            tick();
            chk($sformatf("seg%0d_cyc%0d", s, j),
                32'({pll_rst, rst_out, ready, lock_loss_count}),
                32'({tbl[s].pll, tbl[s].ro, tbl[s].rdy, tbl[s].llc}));
         end
      end

      // 299 more lock losses (300 total) to reach and hold saturation.
      exp_llc = 1;
      for (int i = 0; i < 299; i++) begin
         locked = 1'b0;
         k = 0;
         do begin tick(); k++; end while (pll_rst !== 1'b1 && k < 10);
         if (pll_rst !== 1'b1) begin
            chk($sformatf("loss%0d_pll_rst_timeout", i), 32'(pll_rst), 32'(1));
            break;
         end
         exp_llc = (exp_llc < 255) ? exp_llc + 1 : 255;
         checks++;
         if (lock_loss_count !== 8'(exp_llc) || rst_out !== 3'b111 || ready !== 1'b0) begin
            errors++;
            $display("FAIL loss%0d: llc %0d ro %b rdy %b expected llc %0d ro 111 rdy 0",
                     i, lock_loss_count, rst_out, ready, exp_llc);
         end
         locked = 1'b1;
         k = 0;
         do begin tick(); k++; end while (rst_out !== 3'b110 && k < 60);
         if (rst_out !== 3'b110) begin
            chk($sformatf("relock%0d_timeout", i), 32'(rst_out), 32'(3'b110));
            break;
         end
      end
      chk("llc_saturated", 32'(lock_loss_count), 32'(255));

      // Reset taken mid-RELEASE.
      chk("pre_rst_release", 32'(rst_out), 32'(3'b110));
      rst = 1'b1;
      tick();
      chk("rst_mid_release",
          32'({pll_rst, rst_out, ready, lock_loss_count}),
          32'({1'b1, 3'b111, 1'b0, 8'd0}));

      // Lock arriving exactly at the timeout edge must win.
      rst    = 1'b0;
      locked = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk($sformatf("post_rst_pll%0d", j), 32'(pll_rst), 32'(1));
      end
      tick();                               // X: WAIT_LOCK entered
      chk("wait_lock_entry", 32'(pll_rst), 32'(0));
      repeat (29) tick();                   // X+29
      locked = 1'b1;                        // sampled at X+30
      repeat (3) tick();                    // X+32: timeout and lock coincide
      chk("lock_beats_timeout", 32'({pll_rst, rst_out}), 32'({1'b0, 3'b111}));
      repeat (8) tick();                    // X+40
      chk("coincident_pre_release", 32'(rst_out), 32'(3'b111));
      tick();                               // X+41
      chk("coincident_release", 32'({pll_rst, rst_out, ready}), 32'({1'b0, 3'b110, 1'b0}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL provide parameter PLL_RST_CYCLES, default 16: refclk cycles pll_rst is held high per PLL reset attempt.
REQ-002 SHALL provide parameter LOCK_TIMEOUT_CYCLES, default 1048576: refclk cycles allowed in WAIT_LOCK before retrying the PLL reset.
REQ-003 SHALL provide parameter LOCK_STABLE_CYCLES, default 1024: consecutive cycles of synchronised lock required before reset release.
REQ-004 SHALL provide parameter STAGE_GAP_CYCLES, default 256: cycles between successive rst_out bit releases.
REQ-005 SHALL provide port refclk, input, 1: free-running reference clock (74.25 MHz), sole clock; valid before PLL lock.
REQ-006 SHALL provide port rst, input, 1: reset, synchronous to refclk, active-high.
REQ-007 SHALL provide port locked, input, 1: PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL provide port pll_rst, output, 1: drives the PLL rst input.
REQ-009 SHALL provide port rst_out, output, 3: active-high downstream resets; bit 0 core, bit 1 video, bit 2 audio.
REQ-010 SHALL provide port ready, output, 1: high only in RUN.
REQ-011 SHALL provide port lock_loss_count, output, 8: saturating count of lock losses after release began.

Function
REQ-012 SHALL pass locked through a two-flop synchroniser (locked_sync); only locked_sync SHALL steer the FSM; all outputs SHALL be registered.
REQ-013 SHALL implement states PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN.
REQ-014 PLL_RESET: pll_rst=1, rst_out=3'b111, ready=0; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK with pll_rst=0 and timeout counter cleared.
REQ-015 WAIT_LOCK: locked_sync=1 -> STABLE next cycle, stable counter cleared; else when timeout counter reaches LOCK_TIMEOUT_CYCLES-1 -> PLL_RESET; lock wins on a simultaneous timeout.
REQ-016 STABLE: counts consecutive locked_sync=1 cycles; after LOCK_STABLE_CYCLES -> RELEASE; locked_sync=0 -> WAIT_LOCK with timeout counter cleared; lock_loss_count unchanged.
REQ-017 RELEASE: rst_out[0] SHALL be 0 on the first RELEASE cycle; rst_out[1] SHALL fall STAGE_GAP_CYCLES later; rst_out[2] SHALL fall 2*STAGE_GAP_CYCLES later, in the same cycle ready rises and the state becomes RUN.
REQ-018 Release order SHALL be bit 0 -> 1 -> 2; no bit SHALL deassert before a lower bit.
REQ-019 RELEASE or RUN with locked_sync=0: the next cycle SHALL give rst_out=3'b111, ready=0 and state PLL_RESET; lock_loss_count SHALL increment by 1 and saturate at 255.
REQ-020 Reasserting rst_out SHALL always set all three bits in the same cycle.
REQ-021 Counters SHALL be sized from their parameters (clog2) with no wrap: the timeout counter stops at its terminal value; the stable counter clears on any locked_sync=0.

Reset
REQ-022 rst=1 SHALL, at the next refclk edge, set state PLL_RESET, pll_rst=1, rst_out=3'b111, ready=0, lock_loss_count=0, all counters 0 and synchroniser flops 0; this holds from any state, including mid-RELEASE.
REQ-023 On the first cycle after rst falls, the block SHALL begin a full PLL_RESET period of PLL_RST_CYCLES.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4)
REQ-024 Hold rst 3 cycles, locked=0 -> pll_rst=1 for exactly 4 cycles after rst falls, then 0 for 32 cycles, then 1 again for 4 (retry); rst_out=3'b111 and ready=0 throughout.
REQ-025 First locked=1 sample at edge E in WAIT_LOCK, held high -> rst_out[0] falls at E+11, rst_out[1] at E+15, rst_out[2] and ready at E+19; lock_loss_count=0.
REQ-026 locked drops for 1 cycle midway through STABLE -> return to WAIT_LOCK; full 8-cycle stable count restarts after relock; lock_loss_count stays 0.
REQ-027 locked drops in RUN -> rst_out=3'b111 and ready=0 within 3 cycles of the drop (2 sync + 1), pll_rst=1 for 4 cycles, lock_loss_count=1; 300 such losses -> lock_loss_count=255.
REQ-028 rst asserted in RELEASE with rst_out=3'b110 -> next edge gives rst_out=3'b111, pll_rst=1, lock_loss_count=0, ready=0.
